seq_generator: RTL

Serial pattern transmitter: the generating end of the bit-stream interface consumed by the team's sequence detector. On a start request it latches a pattern, its length, a repeat count and an inter-repetition gap, then drives the pattern MSB-first, one bit per clock, with a qualifying valid. It is used as on-chip stimulus for detector blocks and as a standalone framing-pattern source.

---
 rtl/seq_gen_pkg.sv | 14 +
 rtl/seq_gen_shreg.sv | 72 +++++++
 rtl/seq_generator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } gen_state_t;

   // Reference pattern used when co-simulating with the sequence detector.
   localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_gen_shreg.sv
// Pattern register plus loadable, wrapping bit-index counter (MSB-first).
module seq_gen_shreg
   import seq_gen_pkg::*;
#(
   parameter int unsigned PAT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load_i,
   input  logic                         step_i,
   input  logic [PAT_W-1:0]             pat_i,
   input  logic [$clog2(PAT_W+1)-1:0]   len_i,
   output logic                         bit_nxt_o,
   output logic                         last_o
);

   localparam int unsigned LW = $clog2(PAT_W + 1);
   localparam int unsigned IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [LW-1:0] FULL = LW'(PAT_W);
   localparam logic [LW-1:0] ONE  = LW'(1);

   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LW-1:0]    len_q, len_d, len_eff;
   logic [IW-1:0]    idx_q, idx_d;

   // Clamp zero or oversized lengths to the full pattern width
   always_comb begin
      len_eff = len_i;
      if (len_i == '0 || len_i > FULL) begin
         len_eff = FULL;
      end
   end

   // Next index: load starts at the MSB; stepping past bit 0 wraps back to len-1,
   // so the index is already positioned for the next repetition (with or without gap)
   always_comb begin
      pat_d = pat_q;
      len_d = len_q;
      idx_d = idx_q;
      if (load_i) begin
         pat_d = pat_i;
         len_d = len_eff;
         idx_d = IW'(len_eff - ONE);
      end else if (step_i) begin
         if (idx_q == '0) begin
            idx_d = IW'(len_q - ONE);
         end else begin
            idx_d = idx_q - IW'(1);
         end
      end
   end

   // Pattern, length and index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q <= '0;
         len_q <= '0;
         idx_q <= '0;
      end else begin
         pat_q <= pat_d;
         len_q <= len_d;
         idx_q <= idx_d;
      end
   end

   // Bit that will be on the line next cycle; lets the top register its output
   always_comb begin
      bit_nxt_o = pat_d[idx_d];
      last_o    = (idx_q == '0);
   end

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated with gaps.
module seq_generator
   import seq_gen_pkg::*;
#(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned REP_W = 8,
   parameter int unsigned GAP_W = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic [PAT_W-1:0]             pat_i,
   input  logic [$clog2(PAT_W+1)-1:0]   len_i,
   input  logic [REP_W-1:0]             reps_i,
   input  logic [GAP_W-1:0]             gap_i,
   output logic                         out_bit,
   output logic                         out_valid,
   output logic                         busy,
   output logic                         done
);

   localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   gen_state_t       state_q, state_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
   logic             load, step, bit_nxt, last;
   logic             out_bit_q, out_bit_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   seq_gen_shreg #(
      .PAT_W (PAT_W)
   ) u_shreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load),
      .step_i    (step),
      .pat_i     (pat_i),
      .len_i     (len_i),
      .bit_nxt_o (bit_nxt),
      .last_o    (last)
   );

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rep_q       <= '0;
         gap_q       <= '0;
         gap_cfg_q   <= '0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rep_q       <= rep_d;
         gap_q       <= gap_d;
         gap_cfg_q   <= gap_cfg_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and counter logic; abort wins over every SEND/GAP transition
   always_comb begin
      state_d   = state_q;
      rep_d     = rep_q;
      gap_d     = gap_q;
      gap_cfg_d = gap_cfg_q;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               rep_d     = reps_i;
               gap_cfg_d = gap_i;
               state_d   = (reps_i == '0) ? DONE : SEND;
            end
         end
         SEND: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               step = 1'b1;
               if (last) begin
                  if (rep_q <= REP_ONE) begin
                     rep_d   = '0;
                     state_d = DONE;
                  end else begin
                     rep_d = rep_q - REP_ONE;
                     if (gap_cfg_q != '0) begin
                        gap_d   = gap_cfg_q;
                        state_d = GAP;
                     end
                  end
               end
            end
         end
         GAP: begin
            if (abort) begin
               state_d = IDLE;
            end else if (gap_q <= GAP_ONE) begin
               gap_d   = '0;
               state_d = SEND;
            end else begin
               gap_d = gap_q - GAP_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state
   always_comb begin
      out_valid_d = (state_d == SEND);
      out_bit_d   = out_valid_d & bit_nxt;
      busy_d      = (state_d == SEND) || (state_d == GAP);
      done_d      = (state_d == DONE);
   end

   assign out_bit   = out_bit_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
